// File: rtl/core_boot_pkg.sv
// Shared encodings for the s_core boot/run sequencer: host command codes and FSM states.
package core_boot_pkg;

  typedef enum logic [1:0] {
    CMD_WR_IMEM = 2'd0,
    CMD_WR_REG  = 2'd1,
    CMD_SET_PC  = 2'd2,
    CMD_RUN     = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/core_boot_wdog.sv
// Run-cycle counter (clear, saturating increment) and run-limit compare.
// The limit compare exists only when CORE_BOOT_WDOG_EN is defined.
module core_boot_wdog
  import core_boot_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] run_limit_i,
  output logic [CNT_W-1:0] run_cycles_o,
  output logic             limit_hit_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign run_cycles_o = cnt_q;

`ifdef CORE_BOOT_WDOG_EN
  // Fires in the RUN cycle whose closing edge brings the count up to the limit.
  assign limit_hit_o = en_i && (run_limit_i != '0) && ((cnt_q + CNT_W'(1)) == run_limit_i);
`else
  logic unused_run_limit;
  assign unused_run_limit = ^run_limit_i;
  assign limit_hit_o      = 1'b0;
`endif

endmodule

// File: rtl/core_boot_ctrl.sv
// Boot/run sequencer for s_core: loads imem/regs/start PC in setup mode, runs until
// halt PC, abort, or run limit (limit only with CORE_BOOT_WDOG_EN defined).
module core_boot_ctrl
  import core_boot_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              h_valid,
  output logic              h_ready,
  input  logic [1:0]        h_cmd,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_data,
  input  logic              abort,
  input  logic [ADDR_W-1:0] halt_addr,
  input  logic [CNT_W-1:0]  run_limit,
  input  logic [ADDR_W-1:0] core_pc,
  output logic              core_setup,
  output logic [ADDR_W-1:0] core_start_addr,
  output logic [ADDR_W-1:0] core_imem_addr,
  output logic [DATA_W-1:0] core_imem_data,
  output logic [REG_AW-1:0] core_reg_addr,
  output logic [DATA_W-1:0] core_reg_data,
  output logic              busy,
  output logic              done,
  output logic              halted,
  output logic              timeout,
  output logic              aborted,
  output logic [CNT_W-1:0]  run_cycles
);

  state_e            state_q;
  logic              setup_q, h_ready_q, busy_q, done_q;
  logic              halted_q, timeout_q, aborted_q;
  logic [ADDR_W-1:0] start_q, imem_addr_q;
  logic [DATA_W-1:0] imem_data_q, reg_data_q;
  logic [REG_AW-1:0] reg_addr_q;
  logic              pc_match, limit_hit;

  assign pc_match = (core_pc == halt_addr);

  core_boot_wdog #(.CNT_W(CNT_W)) u_wdog (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (state_q == ST_ARM),
    .en_i         (state_q == ST_RUN),
    .run_limit_i  (run_limit),
    .run_cycles_o (run_cycles),
    .limit_hit_o  (limit_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_LOAD;
      setup_q     <= 1'b1;
      h_ready_q   <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      halted_q    <= 1'b0;
      timeout_q   <= 1'b0;
      aborted_q   <= 1'b0;
      start_q     <= '0;
      imem_addr_q <= '0;
      imem_data_q <= '0;
      reg_addr_q  <= '0;
      reg_data_q  <= '0;
    end else begin
      case (state_q)
        // Load ports hold between commands; the core rewrites the same data harmlessly.
        ST_LOAD, ST_DONE: begin
          if (h_valid && h_ready_q) begin
            state_q   <= ST_LOAD;
            done_q    <= 1'b0;
            halted_q  <= 1'b0;
            timeout_q <= 1'b0;
            aborted_q <= 1'b0;
            case (cmd_e'(h_cmd))
              CMD_WR_IMEM: begin
                imem_addr_q <= h_addr;
                imem_data_q <= h_data;
              end
              CMD_WR_REG: begin
                reg_addr_q <= h_addr[REG_AW-1:0];
                reg_data_q <= h_data;
              end
              CMD_SET_PC: start_q <= h_addr;
              CMD_RUN: begin
                state_q   <= ST_ARM;
                h_ready_q <= 1'b0;
                busy_q    <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        ST_ARM: begin
          state_q <= ST_RUN;
          setup_q <= 1'b0;
        end
        ST_RUN: begin
          if (abort || pc_match || limit_hit) begin
            state_q   <= ST_DONE;
            setup_q   <= 1'b1;
            h_ready_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            aborted_q <= abort;
            halted_q  <= !abort && pc_match;
            timeout_q <= !abort && !pc_match && limit_hit;
          end
        end
        default: state_q <= ST_LOAD;
      endcase
    end
  end

  assign h_ready         = h_ready_q;
  assign core_setup      = setup_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign halted          = halted_q;
  assign timeout         = timeout_q;
  assign aborted         = aborted_q;
  assign core_start_addr = start_q;
  assign core_imem_addr  = imem_addr_q;
  assign core_imem_data  = imem_data_q;
  assign core_reg_addr   = reg_addr_q;
  assign core_reg_data   = reg_data_q;

endmodule

// File: tb/tb_core_boot_ctrl.sv
// Scoreboard bench for core_boot_ctrl: stimulus queues expected load-port and run-end
// records; a negedge monitor compares them when a command lands or done rises.
module tb_core_boot_ctrl;
  import core_boot_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              h_valid, h_ready;
  logic [1:0]        h_cmd;
  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_data;
  logic              abort;
  logic [ADDR_W-1:0] halt_addr;
  logic [CNT_W-1:0]  run_limit;
  logic [ADDR_W-1:0] core_pc = '0;
  logic              core_setup;
  logic [ADDR_W-1:0] core_start_addr, core_imem_addr;
  logic [DATA_W-1:0] core_imem_data, core_reg_data;
  logic [REG_AW-1:0] core_reg_addr;
  logic              busy, done, halted, timeout, aborted;
  logic [CNT_W-1:0]  run_cycles;

  core_boot_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .h_valid(h_valid), .h_ready(h_ready), .h_cmd(h_cmd),
    .h_addr(h_addr), .h_data(h_data), .abort(abort), .halt_addr(halt_addr),
    .run_limit(run_limit), .core_pc(core_pc), .core_setup(core_setup),
    .core_start_addr(core_start_addr), .core_imem_addr(core_imem_addr),
    .core_imem_data(core_imem_data), .core_reg_addr(core_reg_addr),
    .core_reg_data(core_reg_data), .busy(busy), .done(done), .halted(halted),
    .timeout(timeout), .aborted(aborted), .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  // Core model: PC loads the start address in setup, then steps one word per cycle.
  always @(posedge clk) begin
    if (core_setup) core_pc <= core_start_addr;
    else            core_pc <= core_pc + 32'd4;
  end

  typedef struct {
    logic [ADDR_W-1:0] imem_a;
    logic [DATA_W-1:0] imem_d;
    logic [REG_AW-1:0] reg_a;
    logic [DATA_W-1:0] reg_d;
    logic [ADDR_W-1:0] start;
    logic              busy;
    logic              ready;
  } cmd_exp_t;

  typedef struct {
    logic             halted;
    logic             timeout;
    logic             aborted;
    logic [CNT_W-1:0] cycles;
    int               low;
  } done_exp_t;

  cmd_exp_t  cmd_q[$];
  done_exp_t done_q[$];
  int        n_checks = 0;
  int        n_errors = 0;

  // Reference model of the load ports.
  logic [ADDR_W-1:0] m_imem_a = '0, m_start = '0;
  logic [DATA_W-1:0] m_imem_d = '0, m_reg_d = '0;
  logic [REG_AW-1:0] m_reg_a  = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  logic      acc_q     = 1'b0;
  logic      done_prev = 1'b0;
  int        low_cnt   = 0;
  cmd_exp_t  ce;
  done_exp_t de;

  always @(posedge clk) acc_q <= h_valid && h_ready && !rst;

  always @(negedge clk) begin
    if (rst)              low_cnt = 0;
    else if (!core_setup) low_cnt++;

    if (acc_q) begin
      check("cmd_expected", 64'(cmd_q.size() != 0), 64'd1);
      if (cmd_q.size() != 0) begin
        ce = cmd_q.pop_front();
        check("imem_addr",  core_imem_addr,  ce.imem_a);
        check("imem_data",  core_imem_data,  ce.imem_d);
        check("reg_addr",   core_reg_addr,   ce.reg_a);
        check("reg_data",   core_reg_data,   ce.reg_d);
        check("start_addr", core_start_addr, ce.start);
        check("cmd_setup",  core_setup,      1'b1);
        check("cmd_busy",   busy,            ce.busy);
        check("cmd_ready",  h_ready,         ce.ready);
        check("cmd_done",   done,            1'b0);
      end
    end

    if (done && !done_prev) begin
      check("done_expected", 64'(done_q.size() != 0), 64'd1);
      if (done_q.size() != 0) begin
        de = done_q.pop_front();
        check("halted",     halted,     de.halted);
        check("timeout",    timeout,    de.timeout);
        check("aborted",    aborted,    de.aborted);
        check("run_cycles", run_cycles, de.cycles);
        check("setup_low",  64'(low_cnt), 64'(de.low));
        check("done_setup", core_setup, 1'b1);
        check("done_busy",  busy,       1'b0);
        check("done_ready", h_ready,    1'b1);
      end
      low_cnt = 0;
    end
    done_prev = done;
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [1:0] cmd, input logic [ADDR_W-1:0] addr,
                      input logic [DATA_W-1:0] data);
    cmd_exp_t e;
    int       i;
    @(negedge clk);
    h_valid = 1'b1;
    h_cmd   = cmd;
    h_addr  = addr;
    h_data  = data;
    case (cmd)
      2'd0: begin m_imem_a = addr; m_imem_d = data; end
      2'd1: begin m_reg_a = addr[REG_AW-1:0]; m_reg_d = data; end
      2'd2: m_start = addr;
      default: ;
    endcase
    e.imem_a = m_imem_a;
    e.imem_d = m_imem_d;
    e.reg_a  = m_reg_a;
    e.reg_d  = m_reg_d;
    e.start  = m_start;
    e.busy   = (cmd == 2'd3);
    e.ready  = (cmd != 2'd3);
    cmd_q.push_back(e);
    for (i = 0; i < 20; i++) begin
      @(posedge clk);
      if (h_ready) break;
    end
    if (i == 20) check("cmd_accepted", h_ready, 1'b1);
  endtask

  task automatic idle();
    @(negedge clk);
    h_valid = 1'b0;
  endtask

  task automatic expect_done(input logic h, input logic t, input logic a,
                             input logic [CNT_W-1:0] cyc);
    done_exp_t e;
    e.halted  = h;
    e.timeout = t;
    e.aborted = a;
    e.cycles  = cyc;
    e.low     = int'(cyc);
    done_q.push_back(e);
  endtask

  task automatic wait_done(input int bound);
    for (int i = 0; i < bound && !done; i++) @(negedge clk);
    check("done_within_bound", done, 1'b1);
  endtask

  task automatic wait_run_start();
    for (int i = 0; i < 20 && core_setup; i++) @(negedge clk);
    check("run_started", core_setup, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; h_valid = 1'b0; h_cmd = '0; h_addr = '0; h_data = '0;
    abort = 1'b0; halt_addr = '0; run_limit = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_setup",  core_setup, 1'b1);
    check("rst_ready",  h_ready, 1'b1);
    check("rst_busy",   busy, 1'b0);
    check("rst_done",   done, 1'b0);
    check("rst_flags",  {halted, timeout, aborted}, 3'b000);
    check("rst_cycles", run_cycles, '0);
    check("rst_imem",   {core_imem_addr, core_imem_data}, '0);
    check("rst_reg",    {core_reg_addr, core_reg_data}, '0);
    check("rst_start",  core_start_addr, '0);

    // Back-to-back preload.
    send(CMD_WR_IMEM, 32'h4, 32'h0012_7413);
    send(CMD_WR_REG,  32'h4, 32'h1);
    send(CMD_SET_PC,  32'h4, 32'h0);

    // Halt run: PC 4,8,C,10,14.
    halt_addr = 32'h14;
    expect_done(1'b1, 1'b0, 1'b0, 16'd5);
    send(CMD_RUN, 32'h0, 32'h0);
    idle();
    wait_done(50);

    // Halt address equals start PC: single RUN cycle (RUN issued from DONE).
    halt_addr = 32'h4;
    expect_done(1'b1, 1'b0, 1'b0, 16'd1);
    send(CMD_RUN, 32'h0, 32'h0);
    idle();
    wait_done(20);

    // Limit run with an unreachable halt address.
    halt_addr = 32'hFFFF_FFF0;
    run_limit = 16'd20;
`ifdef CORE_BOOT_WDOG_EN
    expect_done(1'b0, 1'b1, 1'b0, 16'd20);
    send(CMD_RUN, 32'h0, 32'h0);
    idle();
    wait_done(60);
`else
    expect_done(1'b0, 1'b0, 1'b1, 16'd25);
    send(CMD_RUN, 32'h0, 32'h0);
    idle();
    wait_run_start();
    repeat (24) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done(20);
`endif
    run_limit = '0;

    // Abort in RUN cycle 3, coincident with a PC match at 0xC.
    halt_addr = 32'hC;
    expect_done(1'b0, 1'b0, 1'b1, 16'd3);
    send(CMD_RUN, 32'h0, 32'h0);
    idle();
    wait_run_start();
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done(20);

    // Reset in the middle of a run.
    halt_addr = 32'hFFFF_FFF0;
    send(CMD_RUN, 32'h0, 32'h0);
    idle();
    wait_run_start();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_setup",  core_setup, 1'b1);
    check("mid_rst_busy",   busy, 1'b0);
    check("mid_rst_ready",  h_ready, 1'b1);
    check("mid_rst_flags",  {done, halted, timeout, aborted}, 4'b0000);
    check("mid_rst_cycles", run_cycles, '0);
    check("mid_rst_ports",  {core_imem_addr, core_reg_data, core_start_addr}, '0);
    rst = 1'b0;
    m_imem_a = '0; m_imem_d = '0; m_reg_a = '0; m_reg_d = '0; m_start = '0;

    send(CMD_WR_REG, 32'h7, 32'hDEAD_BEEF);
    idle();

    // Abort outside RUN has no effect.
    abort = 1'b1;
    repeat (2) @(negedge clk);
    abort = 1'b0;
    check("idle_abort_busy",  busy, 1'b0);
    check("idle_abort_flags", {done, aborted}, 2'b00);
    check("idle_abort_setup", core_setup, 1'b1);

    repeat (3) @(negedge clk);
    check("cmd_queue_drained",  64'(cmd_q.size()), 64'd0);
    check("done_queue_drained", 64'(done_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete in time");
    $fatal(1, "time limit reached");
  end

endmodule
